stud_dsdemod: RTL

//  1-bit delta-sigma demodulator: CIC (sinc^ORDER) decimator turning the modulator bitstream back into unsigned PCM.

---
 rtl/stud_dsdemod_pkg.sv | 19 +
 rtl/stud_cic_comb.sv | 37 +++
 rtl/stud_dsdemod.sv | 104 ++++++++++
 3 files changed

// File: rtl/stud_dsdemod_pkg.sv
// Shared constants for the stud_dsdemod CIC decimator: default geometry,
// internal width derivation and the bitstream-to-value mapping.
package stud_dsdemod_pkg;

    localparam int unsigned BITWIDTH_DEF = 32'd16;
    localparam int unsigned ORDER_DEF    = 32'd3;
    localparam int unsigned OSR_LOG2_DEF = 32'd6;

    // Bitstream level that represents +1; the other level represents 0.
    localparam logic MOD_ONE = 1'b1;

    // Register growth of a sinc^order filter with ratio 2^osr_log2, plus one
    // bit so the full-scale value 2^(order*osr_log2) is representable.
    function automatic int unsigned cic_width(input int unsigned order,
                                              input int unsigned osr_log2);
        return order * osr_log2 + 32'd1;
    endfunction

endpackage

// File: rtl/stud_cic_comb.sv
// One CIC comb stage: y = x - x_prev (modulo 2^W), x_prev captured on ticks.
module stud_cic_comb
    import stud_dsdemod_pkg::*;
#(
    parameter int unsigned W = cic_width(ORDER_DEF, OSR_LOG2_DEF)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    logic [W-1:0] x_prev_q;
    logic [W-1:0] x_prev_d;

    // Hold the previous decimated input between ticks.
    always_comb begin
        if (en_i) begin
            x_prev_d = x_i;
        end else begin
            x_prev_d = x_prev_q;
        end
    end

    // Delay register, cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_prev_q <= {W{1'b0}};
        end else begin
            x_prev_q <= x_prev_d;
        end
    end

    assign y_o = x_i - x_prev_q;

endmodule

// File: rtl/stud_dsdemod.sv
// 1-bit delta-sigma demodulator: sinc^ORDER CIC decimator by 2^OSR_LOG2,
// producing unsigned BITWIDTH PCM with a one-cycle strobe per output sample.
module stud_dsdemod
    import stud_dsdemod_pkg::*;
#(
    parameter int unsigned BITWIDTH = BITWIDTH_DEF,
    parameter int unsigned ORDER    = ORDER_DEF,
    parameter int unsigned OSR_LOG2 = OSR_LOG2_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mod_i,
    output logic [BITWIDTH-1:0] data_o,
    output logic                valid_o
);

    localparam int unsigned W  = cic_width(ORDER, OSR_LOG2);
    localparam int unsigned SW = $clog2(ORDER + 32'd1);
    localparam logic [SW-1:0]       SETTLE_MAX = SW'(ORDER);
    localparam logic [OSR_LOG2-1:0] CNT_LAST   = {OSR_LOG2{1'b1}};
    localparam logic [W-1:0]        FULL_SCALE = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0]          integ_q [ORDER];
    logic [W-1:0]          integ_d [ORDER];
    logic [W-1:0]          comb_x  [ORDER+1];
    logic [OSR_LOG2-1:0]   cnt_q;
    logic [OSR_LOG2-1:0]   cnt_d;
    logic [SW-1:0]         settle_q;
    logic [SW-1:0]         settle_d;
    logic [BITWIDTH-1:0]   data_q;
    logic [BITWIDTH-1:0]   data_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  tick;
    logic [W-1:0]          cic_out;

    assign tick    = (cnt_q == CNT_LAST);
    assign comb_x[0] = integ_q[ORDER-1];
    assign cic_out = comb_x[ORDER];

    // The comb chain sees the pre-edge last integrator; each stage only
    // updates its delay on ticks, so the whole chain runs at the output rate.
    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        stud_cic_comb #(.W(W)) u_comb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (tick),
            .x_i   (comb_x[g]),
            .y_o   (comb_x[g+1])
        );
    end

    // Next-state logic: integrators, phase counter, settling and output.
    always_comb begin
        integ_d[0] = integ_q[0] + {{(W-1){1'b0}}, (mod_i == MOD_ONE)};
        for (int i = 1; i < ORDER; i++) begin
            integ_d[i] = integ_q[i] + integ_q[i-1];
        end
        cnt_d    = cnt_q + {{(OSR_LOG2-1){1'b0}}, 1'b1};
        settle_d = settle_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        if (tick) begin
            // The first ORDER ticks only fill the comb delays.
            if (settle_q == SETTLE_MAX) begin
                valid_d = 1'b1;
                if (cic_out == FULL_SCALE) begin
                    data_d = {BITWIDTH{1'b1}};
                end else begin
                    data_d = cic_out[W-2 -: BITWIDTH];
                end
            end else begin
                settle_d = settle_q + {{(SW-1){1'b0}}, 1'b1};
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset takes priority over a coincident tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ORDER; i++) begin
                integ_q[i] <= {W{1'b0}};
            end
            cnt_q    <= {OSR_LOG2{1'b0}};
            settle_q <= {SW{1'b0}};
            data_q   <= {BITWIDTH{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < ORDER; i++) begin
                integ_q[i] <= integ_d[i];
            end
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule
